// File: rtl/ram_controller.sv
// ram_controller: byte-addressed internal RAM with a mov/mfc handshake.
// A request is latched in IDLE, waits WAIT_CYCLES+1 cycles, performs the
// access in one cycle, then holds DONE (mfc=1) until mov is released.
// Data is stored big-endian. Sizes: 00 byte, 01 halfword, 10 word, 11 reserved.
// Optional macro RAM_ALIGN_CHECK_EN: flag misaligned halfword/word accesses
// on addr_err and suppress them; when undefined, low address bits are forced
// to the natural alignment instead and addr_err is tied low.
module ram_controller #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned MEM_DEPTH   = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mov,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic [7:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        mfc,
  output logic        busy,
  output logic        addr_err
);

  localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rw_q;
  logic [1:0]  size_q;
  logic [7:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] data_out_q;
  logic [31:0] rdata;
  logic [7:0]  eff_addr;
  logic        misaligned;
  logic        do_access;
  logic [IdxW-1:0] idx0, idx1, idx2, idx3;

  // Contents survive reset, so this array has no reset branch.
  logic [7:0] mem [MEM_DEPTH];

  function automatic logic [IdxW-1:0] byte_idx(input logic [7:0] a, input logic [1:0] k);
    int unsigned sum;
    sum = 32'(a) + 32'(k);
    return IdxW'(sum % MEM_DEPTH);
  endfunction

  // Effective address and alignment status of the latched request.
  always_comb begin
    eff_addr   = addr_q;
    misaligned = 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
    misaligned = ((size_q == 2'b01) && addr_q[0]) ||
                 ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`else
    if (size_q == 2'b01) begin
      eff_addr[0] = 1'b0;
    end else if (size_q == 2'b10) begin
      eff_addr[1:0] = 2'b00;
    end
`endif
  end

  assign idx0 = byte_idx(eff_addr, 2'd0);
  assign idx1 = byte_idx(eff_addr, 2'd1);
  assign idx2 = byte_idx(eff_addr, 2'd2);
  assign idx3 = byte_idx(eff_addr, 2'd3);

  // Reserved size and misaligned requests complete the handshake without touching memory.
  assign do_access = (state_q == StAccess) && (size_q != 2'b11) && !misaligned;

  // Big-endian read assembly, zero-extended.
  always_comb begin
    rdata = '0;
    case (size_q)
      2'b00:   rdata = {24'h0, mem[idx0]};
      2'b01:   rdata = {16'h0, mem[idx0], mem[idx1]};
      2'b10:   rdata = {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};
      default: rdata = '0;
    endcase
  end

  // Next-state logic for the handshake FSM and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mov) begin
          state_d = StWait;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StAccess;
        end
      end
      StAccess: state_d = StDone;
      StDone: begin
        if (!mov) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch: inputs are captured only on the accepting edge in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 8'h00;
      wdata_q <= 32'h0;
    end else if ((state_q == StIdle) && mov) begin
      rw_q    <= rw;
      size_q  <= size;
      addr_q  <= addr;
      wdata_q <= data_in;
    end
  end

  // Read data register, updated only by a successful read access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q <= 32'h0;
    end else if (do_access && rw_q) begin
      data_out_q <= rdata;
    end
  end

  // Memory write port; reset forces IDLE asynchronously so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (do_access && !rw_q) begin
      case (size_q)
        2'b00: mem[idx0] <= wdata_q[7:0];
        2'b01: begin
          mem[idx0] <= wdata_q[15:8];
          mem[idx1] <= wdata_q[7:0];
        end
        2'b10: begin
          mem[idx0] <= wdata_q[31:24];
          mem[idx1] <= wdata_q[23:16];
          mem[idx2] <= wdata_q[15:8];
          mem[idx3] <= wdata_q[7:0];
        end
        default: ;
      endcase
    end
  end

  assign data_out = data_out_q;
  assign mfc      = (state_q == StDone);
  assign busy     = (state_q != StIdle);
`ifdef RAM_ALIGN_CHECK_EN
  assign addr_err = mfc && misaligned;
`else
  assign addr_err = 1'b0;
`endif

endmodule
